// File: rtl/cclut_clct_ring_buffer_if.sv
// Write/readout bus of the CLCT ring buffer: per-BX store inputs and the framed readout stream.
// The upstream/readout side uses the master modport; the buffer uses the slave modport.
interface cclut_clct_ring_buffer_if #(
    parameter int MXXKYB  = 10,
    parameter int MXOFFSB = 4,
    parameter int MXBNDB  = 5,
    parameter int MXBXNB  = 12,
    parameter int MXADRB  = 5
);
    localparam int RDW = 2 + MXBNDB + MXOFFSB + MXXKYB;

    logic               wr_en;
    logic [MXBXNB-1:0]  bxn;
    logic               clct0_vld;
    logic [MXXKYB-1:0]  clct0_subkey;
    logic [MXOFFSB-1:0] clct0_offs;
    logic [MXBNDB-1:0]  clct0_bend;
    logic               clct1_vld;
    logic [MXXKYB-1:0]  clct1_subkey;
    logic [MXOFFSB-1:0] clct1_offs;
    logic [MXBNDB-1:0]  clct1_bend;
    logic               rd_req;
    logic [MXADRB-1:0]  rd_delay;
    logic               rd_busy;
    logic               rd_vld;
    logic               rd_last;
    logic [RDW-1:0]     rd_data;
    logic               rd_drop;

    modport master (
        output wr_en, bxn,
               clct0_vld, clct0_subkey, clct0_offs, clct0_bend,
               clct1_vld, clct1_subkey, clct1_offs, clct1_bend,
               rd_req, rd_delay,
        input  rd_busy, rd_vld, rd_last, rd_data, rd_drop
    );

    modport slave (
        input  wr_en, bxn,
               clct0_vld, clct0_subkey, clct0_offs, clct0_bend,
               clct1_vld, clct1_subkey, clct1_offs, clct1_bend,
               rd_req, rd_delay,
        output rd_busy, rd_vld, rd_last, rd_data, rd_drop
    );
endinterface

// File: rtl/cclut_clct_ring_buffer.sv
// Circular history of per-BX CCLUT results; a readout request replays the entry rd_delay BXs back
// as a header word followed by one word per valid CLCT.
module cclut_clct_ring_buffer #(
    parameter int MXXKYB  = 10,
    parameter int MXOFFSB = 4,
    parameter int MXBNDB  = 5,
    parameter int MXBXNB  = 12,
    parameter int MXADRB  = 5
) (
    input  logic clock,
    input  logic reset,
    cclut_clct_ring_buffer_if.slave bus
);
    localparam int DEPTH = 1 << MXADRB;
    localparam int CLCTB = MXBNDB + MXOFFSB + MXXKYB;
    localparam int HPADB = CLCTB - 3 - MXBXNB;

    // Packed order gives {bxn, vld1, vld0, clct1, clct0}
    typedef struct packed {
        logic [MXBXNB-1:0]       bxn;
        logic [1:0]              vld;
        logic [1:0][CLCTB-1:0]   clct;
    } entry_t;

    typedef enum logic [2:0] {IDLE, FETCH, HDR, C0, C1} state_t;

    logic                  wr_en_r;
    entry_t                wr_ent;
    entry_t                mem [DEPTH];
    entry_t                ram_q;
    logic [MXADRB-1:0]     wr_adr;
    logic [MXADRB:0]       fill;
    logic [MXADRB-1:0]     rd_adr;
    logic                  stale_q;
    logic                  drop_q;
    state_t                state, state_nxt;
    logic [1:0]            vld_eff;

    // Input registration stage
    always_ff @(posedge clock) begin
        if (reset) wr_en_r <= 1'b0;
        else       wr_en_r <= bus.wr_en;
    end

    always_ff @(posedge clock) begin
        wr_ent.bxn     <= bus.bxn;
        wr_ent.vld     <= {bus.clct1_vld, bus.clct0_vld};
        wr_ent.clct[0] <= {bus.clct0_bend, bus.clct0_offs, bus.clct0_subkey};
        wr_ent.clct[1] <= {bus.clct1_bend, bus.clct1_offs, bus.clct1_subkey};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_adr <= '0;
            fill   <= '0;
        end else if (wr_en_r) begin
            wr_adr <= wr_adr + MXADRB'(1);
            if (fill != (MXADRB+1)'(DEPTH)) fill <= fill + (MXADRB+1)'(1);
        end
    end

    // Read-first RAM: a same-cycle write to rd_adr leaves the old entry in ram_q
    always_ff @(posedge clock) begin
        if (wr_en_r && !reset) mem[wr_adr] <= wr_ent;
        if (state == FETCH)    ram_q       <= mem[rd_adr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            rd_adr  <= '0;
            stale_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= bus.rd_req && (state != IDLE);
            if (state == IDLE && bus.rd_req) begin
                rd_adr  <= wr_adr - MXADRB'(1) - bus.rd_delay;
                stale_q <= {1'b0, bus.rd_delay} >= fill;
            end
        end
    end

    assign vld_eff     = stale_q ? 2'b00 : ram_q.vld;
    assign bus.rd_busy = (state != IDLE);
    assign bus.rd_drop = drop_q;

    always_comb begin
        state_nxt   = state;
        bus.rd_vld  = 1'b0;
        bus.rd_last = 1'b0;
        bus.rd_data = '0;
        case (state)
            IDLE:  if (bus.rd_req) state_nxt = FETCH;
            FETCH: state_nxt = HDR;
            HDR: begin
                bus.rd_vld  = 1'b1;
                bus.rd_data = {2'b01, stale_q, vld_eff[1], vld_eff[0], {HPADB{1'b0}}, ram_q.bxn};
                if (vld_eff[0])      state_nxt = C0;
                else if (vld_eff[1]) state_nxt = C1;
                else begin
                    bus.rd_last = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            C0: begin
                bus.rd_vld  = 1'b1;
                bus.rd_data = {2'b10, ram_q.clct[0]};
                if (vld_eff[1]) state_nxt = C1;
                else begin
                    bus.rd_last = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            C1: begin
                bus.rd_vld  = 1'b1;
                bus.rd_last = 1'b1;
                bus.rd_data = {2'b11, ram_q.clct[1]};
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
